// File: rtl/uart_pkg.sv
// Constants and types shared by the UART TX and RX sides: divider tops for the
// 50 MHz baud table, baud_sel encodings and the TX state codes.
package uart_pkg;

  localparam int DIV_W = 13;

  localparam logic [DIV_W-1:0] BPS9600   = 13'd5207;
  localparam logic [DIV_W-1:0] BPS19200  = 13'd2603;
  localparam logic [DIV_W-1:0] BPS38400  = 13'd1301;
  localparam logic [DIV_W-1:0] BPS57600  = 13'd867;
  localparam logic [DIV_W-1:0] BPS115200 = 13'd433;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_t;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  // Unused encodings 5..7 fall back to the slowest rate.
  function automatic logic [DIV_W-1:0] baud_top(input logic [2:0] sel);
    case (sel)
      BAUD_19200:  return BPS19200;
      BAUD_38400:  return BPS38400;
      BAUD_57600:  return BPS57600;
      BAUD_115200: return BPS115200;
      default:     return BPS9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts 0..top and flags the last clock of each bit so the
// owning FSM can advance on the same edge the count wraps.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] top_in,
  output logic             bit_end
);

  logic [DIV_W-1:0] top_q, top_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (load) begin
      top_d = top_in;
      cnt_d = '0;
    end else if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == top_q) ? '0 : cnt_q + 13'd1;
    end
  end

  assign bit_end = run && (cnt_q == top_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: accepts a byte over valid/ready and serialises it as
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_sel,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam logic STOP_LAST   = (STOP_BITS == 2);
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       parity_q, parity_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       load;
  logic       idle;
  logic       bit_end;

  assign idle = (state_q == ST_IDLE);

  uart_bit_timer u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (idle),
    .load    (load),
    .run     (!idle),
    .top_in  (baud_top(baud_sel)),
    .bit_end (bit_end)
  );

  // txd_d always holds the level of the bit that starts on the next edge, so
  // the pin is a plain flop and changes exactly on the divider wrap.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          load       = 1'b1;
          shift_d    = tx_data;
          parity_d   = (^tx_data) ^ PAR_ODD_BIT;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          txd_d      = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              txd_d   = parity_q;
              state_d = ST_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = idle;
  assign tx_busy  = !idle;
  assign tx_done  = done_q;
  assign txd      = txd_q;

endmodule
